ex_top: RTL and testbench



---
 rtl/ex_top.sv | 176 +++++++++++++++++
 tb/tb_ex_top.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ex_top.sv
// ex_top: stand-alone MIPS execute stage for ALU bring-up.
// An 8-entry stimulus ROM stands in for the ID stage. It feeds an ID/EX register,
// then ALU control, then a 32-bit ALU, then the EX/MEM output register.
//
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset (priority over enable)
//   enable  - pipeline advance; 0 freezes all state
//   read_in - fetch ROM[ptr] into ID/EX on this edge
//   result  - registered ALU result
//   cout    - registered adder carry-out (add/sub only, else 0)
//   zero    - registered result==0 flag
//
// Optional feature: define EX_SHIFT_EN to add funct 000000 (sll) and 000010 (srl).
module ex_top (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        read_in,
  output logic [31:0] result,
  output logic        cout,
  output logic        zero
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic        alusrc;
  } entry_t;

  typedef enum logic [3:0] {
    CtlNone, CtlAdd, CtlSub, CtlAnd, CtlOr, CtlNor, CtlSlt, CtlSll, CtlSrl
  } alu_ctl_e;

  logic [2:0]  ptr_q;
  entry_t      idex_q;
  logic        idex_valid_q;
  entry_t      rom_entry;

  logic [31:0] op2;
  alu_ctl_e    ctl;
  logic [32:0] sum;
  logic [31:0] alu_res;
  logic        alu_cout;

  logic [31:0] result_q;
  logic        cout_q;
  logic        zero_q;

  // Stimulus ROM
  always_comb begin
    rom_entry = '0;
    unique case (ptr_q)
      3'd0: begin
        rom_entry.a = 32'd5;  rom_entry.b = 32'd3;
        rom_entry.aluop = 2'b10; rom_entry.funct = 6'b100000;
      end
      3'd1: begin
        rom_entry.a = 32'd5;  rom_entry.b = 32'd5;
        rom_entry.aluop = 2'b01;
      end
      3'd2: begin
        rom_entry.a = 32'hFFFF_FFFF; rom_entry.b = 32'd1;
        rom_entry.aluop = 2'b10; rom_entry.funct = 6'b100000;
      end
      3'd3: begin
        rom_entry.a = 32'h0000_F0F0; rom_entry.b = 32'h00FF_00FF;
        rom_entry.aluop = 2'b10; rom_entry.funct = 6'b100100;
      end
      3'd4: begin
        rom_entry.a = 32'h0000_F0F0; rom_entry.b = 32'h00FF_00FF;
        rom_entry.aluop = 2'b10; rom_entry.funct = 6'b100101;
      end
      3'd5: begin
        rom_entry.a = 32'd3;  rom_entry.b = 32'd7;
        rom_entry.aluop = 2'b10; rom_entry.funct = 6'b101010;
      end
      3'd6: begin
        rom_entry.a = 32'h10; rom_entry.imm = 16'hFFFC;
        rom_entry.aluop = 2'b00; rom_entry.alusrc = 1'b1;
      end
      default: begin
        rom_entry.aluop = 2'b10; rom_entry.funct = 6'b100111;
      end
    endcase
  end

  // ALU control decode
  always_comb begin
    ctl = CtlNone;
    case (idex_q.aluop)
      2'b00: ctl = CtlAdd;
      2'b01: ctl = CtlSub;
      2'b10: begin
        case (idex_q.funct)
          6'b100000: ctl = CtlAdd;
          6'b100010: ctl = CtlSub;
          6'b100100: ctl = CtlAnd;
          6'b100101: ctl = CtlOr;
          6'b100111: ctl = CtlNor;
          6'b101010: ctl = CtlSlt;
`ifdef EX_SHIFT_EN
          6'b000000: ctl = CtlSll;
          6'b000010: ctl = CtlSrl;
`endif
          default:   ctl = CtlNone;
        endcase
      end
      default: ctl = CtlNone;
    endcase
  end

  // ALU datapath; subtraction is A + ~op2 + 1 so cout=1 means no borrow
  always_comb begin
    op2      = idex_q.alusrc ? {{16{idex_q.imm[15]}}, idex_q.imm} : idex_q.b;
    sum      = '0;
    alu_res  = '0;
    alu_cout = 1'b0;
    case (ctl)
      CtlAdd: begin
        sum      = {1'b0, idex_q.a} + {1'b0, op2};
        alu_res  = sum[31:0];
        alu_cout = sum[32];
      end
      CtlSub: begin
        sum      = {1'b0, idex_q.a} + {1'b0, ~op2} + 33'd1;
        alu_res  = sum[31:0];
        alu_cout = sum[32];
      end
      CtlAnd:  alu_res = idex_q.a & op2;
      CtlOr:   alu_res = idex_q.a | op2;
      CtlNor:  alu_res = ~(idex_q.a | op2);
      CtlSlt:  alu_res = {31'd0, $signed(idex_q.a) < $signed(op2)};
      CtlSll:  alu_res = op2 << idex_q.shamt;
      CtlSrl:  alu_res = op2 >> idex_q.shamt;
      default: alu_res = '0;
    endcase
  end

  // Pointer and ID/EX register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      idex_valid_q <= 1'b0;
      idex_q       <= '0;
    end else if (enable) begin
      idex_valid_q <= read_in;
      if (read_in) begin
        idex_q <= rom_entry;
        ptr_q  <= ptr_q + 3'd1;
      end
    end
  end

  // EX/MEM output register; bubbles leave it untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else if (enable && idex_valid_q) begin
      result_q <= alu_res;
      cout_q   <= alu_cout;
      zero_q   <= (alu_res == 32'd0);
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_ex_top.sv
module tb_ex_top;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        read_in;
  logic [31:0] result;
  logic        cout;
  logic        zero;

  int vectors;
  int miscompares;

  // Reference model: expected per-row outputs, a fetch counter, a one-slot in-flight row
  logic [31:0] row_res  [8];
  logic        row_cout [8];
  int          m_ptr;
  bit          m_valid;
  int          m_idx;
  logic [31:0] m_res;
  logic        m_cout;
  logic        m_zero;

  ex_top dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .read_in (read_in),
    .result  (result),
    .cout    (cout),
    .zero    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one edge of stimulus and advance the model; sampling happens 1 unit after the edge
  task automatic step(input bit r, input bit en, input bit rd);
    rst     = r;
    enable  = en;
    read_in = rd;
    @(posedge clk);
    if (r) begin
      m_ptr = 0; m_valid = 0; m_res = '0; m_cout = 1'b0; m_zero = 1'b0;
    end else if (en) begin
      if (m_valid) begin
        m_res  = row_res[m_idx];
        m_cout = row_cout[m_idx];
        m_zero = (row_res[m_idx] == 32'd0);
      end
      m_valid = rd;
      if (rd) begin
        m_idx = m_ptr;
        m_ptr = (m_ptr + 1) % 8;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0);
    vectors++;
    if ({result, cout, zero} !== {32'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got %h/%b/%b want 0/0/0", result, cout, zero);
    end
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    vectors++;
    if ({result, cout, zero} !== {32'd8, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_first_fetch: got %h/%b/%b want 8/0/0", result, cout, zero);
    end
  endtask

  task automatic test_streaming();
    int row;
    step(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1, 1'b1);
      if (k >= 2) begin
        row = (k - 2) % 8;
        vectors++;
        if ({result, cout, zero} !== {row_res[row], row_cout[row], row_res[row] == 32'd0}) begin
          miscompares++;
          $display("FAIL stream edge %0d: got %h/%b/%b want %h/%b/%b", k, result, cout, zero,
                   row_res[row], row_cout[row], row_res[row] == 32'd0);
        end
      end
    end
  endtask

  task automatic test_stall();
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, k[0]);
      vectors++;
      if ({result, cout, zero} !== {32'd0, 1'b1, 1'b1}) begin
        miscompares++;
        $display("FAIL stall hold %0d: got %h/%b/%b want 0/1/1", k, result, cout, zero);
      end
    end
    step(1'b0, 1'b1, 1'b1);
    vectors++;
    if ({result, cout, zero} !== {32'd0, 1'b1, 1'b1} || m_idx != 3) begin
      miscompares++;
      $display("FAIL stall resume: got %h/%b/%b want row2 0/1/1", result, cout, zero);
    end
    step(1'b0, 1'b1, 1'b1);
    vectors++;
    if ({result, cout, zero} !== {32'h0000_00F0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL stall row3: got %h/%b/%b want 000000f0/0/0", result, cout, zero);
    end
  endtask

  task automatic test_bubble();
    // Continues from test_stall: row 4 is in ID/EX
    bit rd_seq [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] want [5] = '{32'h00FF_F0FF, 32'h00FF_F0FF, 32'h00FF_F0FF, 32'd1, 32'h0000_000C};
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, rd_seq[k]);
      vectors++;
      if (result !== want[k] || {result, cout, zero} !== {m_res, m_cout, m_zero}) begin
        miscompares++;
        $display("FAIL bubble %0d: got %h/%b/%b want %h (model %h/%b/%b)", k, result, cout, zero,
                 want[k], m_res, m_cout, m_zero);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit seen4;
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    vectors++;
    if ({result, cout, zero} !== {32'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset clear: got %h/%b/%b want 0/0/0", result, cout, zero);
    end
    seen4 = 0;
    step(1'b0, 1'b1, 1'b1);
    if (result === 32'h00FF_F0FF) seen4 = 1;
    step(1'b0, 1'b1, 1'b1);
    vectors++;
    if (seen4 || {result, cout, zero} !== {32'd8, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset restart: got %h/%b/%b want 8/0/0 (row4 seen=%0d)",
               result, cout, zero, seen4);
    end
  endtask

  task automatic test_random();
    bit r, en, rd;
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 300; k++) begin
      r  = ($urandom_range(0, 19) == 0);
      en = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 3) != 0);
      step(r, en, rd);
      vectors++;
      if ({result, cout, zero} !== {m_res, m_cout, m_zero}) begin
        miscompares++;
        $display("FAIL random %0d (rst=%b en=%b rd=%b): got %h/%b/%b want %h/%b/%b", k, r, en,
                 rd, result, cout, zero, m_res, m_cout, m_zero);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_ptr = 0; m_valid = 0; m_idx = 0; m_res = '0; m_cout = 1'b0; m_zero = 1'b0;
    row_res[0] = 32'd8;          row_cout[0] = 1'b0;
    row_res[1] = 32'd0;          row_cout[1] = 1'b1;
    row_res[2] = 32'd0;          row_cout[2] = 1'b1;
    row_res[3] = 32'h0000_00F0;  row_cout[3] = 1'b0;
    row_res[4] = 32'h00FF_F0FF;  row_cout[4] = 1'b0;
    row_res[5] = 32'd1;          row_cout[5] = 1'b0;
    row_res[6] = 32'h0000_000C;  row_cout[6] = 1'b1;
    row_res[7] = 32'hFFFF_FFFF;  row_cout[7] = 1'b0;
    rst = 1'b1; enable = 1'b0; read_in = 1'b0;
    @(negedge clk);

    test_reset();
    test_streaming();
    test_stall();
    test_bubble();
    test_mid_reset();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
